// File: rtl/hms_time_counter.sv
// BCD HH.MM.SS time-of-day counter with a button-driven hour/minute set mode.
// Define HMS_12_HOUR_EN to remap the displayed hour digits to 12-hour format with a PM dot.
module hms_time_counter #(
  parameter int INIT_HOURS   = 0,
  parameter int INIT_MINUTES = 0,
  parameter int INIT_SECONDS = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick,
  input  logic        mode_btn,
  input  logic        inc_btn,
  input  logic        dec_btn,
  output logic [31:0] bcd,
  output logic [7:0]  dots,
  output logic [1:0]  mode,
  output logic        rollover
);

  typedef enum logic [1:0] {
    MODE_RUN         = 2'd0,
    MODE_SET_HOURS   = 2'd1,
    MODE_SET_MINUTES = 2'd2
  } mode_e;

  if (INIT_HOURS < 0 || INIT_HOURS > 23 ||
      INIT_MINUTES < 0 || INIT_MINUTES > 59 ||
      INIT_SECONDS < 0 || INIT_SECONDS > 59) begin : g_init_range_check
    $error("hms_time_counter: INIT_HOURS/INIT_MINUTES/INIT_SECONDS out of range");
  end

  localparam logic [7:0] INIT_HOURS_BCD   = {4'(INIT_HOURS / 10),   4'(INIT_HOURS % 10)};
  localparam logic [7:0] INIT_MINUTES_BCD = {4'(INIT_MINUTES / 10), 4'(INIT_MINUTES % 10)};
  localparam logic [7:0] INIT_SECONDS_BCD = {4'(INIT_SECONDS / 10), 4'(INIT_SECONDS % 10)};
`ifdef HMS_12_HOUR_EN
  localparam logic [7:0] INIT_DOTS = (INIT_HOURS >= 12) ? 8'h01 : 8'h00;
`else
  localparam logic [7:0] INIT_DOTS = 8'h00;
`endif

  // Two-digit BCD increment, wrapping max_v -> 00.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max_v);
    logic [7:0] r;
    if (v == max_v) begin
      r = 8'h00;
    end else if (v[3:0] == 4'd9) begin
      r = {v[7:4] + 4'd1, 4'd0};
    end else begin
      r = {v[7:4], v[3:0] + 4'd1};
    end
    return r;
  endfunction

  // Two-digit BCD decrement, wrapping 00 -> max_v.
  function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] max_v);
    logic [7:0] r;
    if (v == 8'h00) begin
      r = max_v;
    end else if (v[3:0] == 4'd0) begin
      r = {v[7:4] - 4'd1, 4'd9};
    end else begin
      r = {v[7:4], v[3:0] - 4'd1};
    end
    return r;
  endfunction

  function automatic logic [7:0] hour_display(input logic [7:0] h);
`ifdef HMS_12_HOUR_EN
    logic [4:0] hb;
    logic [4:0] hd;
    logic [7:0] r;
    hb = 5'(h[7:4]) * 5'd10 + 5'(h[3:0]);
    if (hb == 5'd0) begin
      hd = 5'd12;
    end else if (hb > 5'd12) begin
      hd = hb - 5'd12;
    end else begin
      hd = hb;
    end
    if (hd >= 5'd10) begin
      r = {4'd1, 4'(hd - 5'd10)};
    end else begin
      r = {4'd0, 4'(hd)};
    end
    return r;
`else
    return h;
`endif
  endfunction

  logic [7:0]  hours_q, hours_d;
  logic [7:0]  minutes_q, minutes_d;
  logic [7:0]  seconds_q, seconds_d;
  mode_e       mode_q, mode_d;
  logic        blink_q, blink_d;
  logic        rollover_q, rollover_d;
  logic [31:0] bcd_q, bcd_d;
  logic [7:0]  dots_q, dots_d;
  logic        sec_wrap, min_wrap, day_wrap;
  logic        inc_only, dec_only;

  assign sec_wrap = (seconds_q == 8'h59);
  assign min_wrap = (minutes_q == 8'h59);
  assign day_wrap = sec_wrap && min_wrap && (hours_q == 8'h23);
  assign inc_only = inc_btn && !dec_btn;
  assign dec_only = dec_btn && !inc_btn;

  // Next-state for time fields, set-mode FSM, blink and rollover.
  always_comb begin
    hours_d    = hours_q;
    minutes_d  = minutes_q;
    seconds_d  = seconds_q;
    mode_d     = mode_q;
    blink_d    = blink_q;
    rollover_d = 1'b0;
    case (mode_q)
      MODE_RUN: begin
        if (tick) begin
          seconds_d  = bcd_inc(seconds_q, 8'h59);
          minutes_d  = sec_wrap ? bcd_inc(minutes_q, 8'h59) : minutes_q;
          hours_d    = (sec_wrap && min_wrap) ? bcd_inc(hours_q, 8'h23) : hours_q;
          rollover_d = day_wrap;
        end else begin
          rollover_d = 1'b0;
        end
        // A tick coinciding with mode_btn still advances time; the transition clears blink.
        if (mode_btn) begin
          mode_d  = MODE_SET_HOURS;
          blink_d = 1'b0;
        end else begin
          blink_d = blink_q ^ tick;
        end
      end
      MODE_SET_HOURS: begin
        if (mode_btn) begin
          mode_d  = MODE_SET_MINUTES;
          blink_d = 1'b0;
        end else begin
          blink_d = blink_q ^ tick;
          if (inc_only) begin
            hours_d = bcd_inc(hours_q, 8'h23);
          end else if (dec_only) begin
            hours_d = bcd_dec(hours_q, 8'h23);
          end else begin
            hours_d = hours_q;
          end
        end
      end
      MODE_SET_MINUTES: begin
        if (mode_btn) begin
          mode_d    = MODE_RUN;
          blink_d   = 1'b0;
          seconds_d = 8'h00;
        end else begin
          blink_d = blink_q ^ tick;
          if (inc_only) begin
            minutes_d = bcd_inc(minutes_q, 8'h59);
          end else if (dec_only) begin
            minutes_d = bcd_dec(minutes_q, 8'h59);
          end else begin
            minutes_d = minutes_q;
          end
        end
      end
      default: begin
        mode_d  = MODE_RUN;
        blink_d = 1'b0;
      end
    endcase
  end

  // Display image computed from next state so outputs track state with no extra lag.
  always_comb begin
    bcd_d  = {8'h00, hour_display(hours_d), minutes_d, seconds_d};
    dots_d = 8'h00;
    case (mode_d)
      MODE_RUN: begin
        dots_d[2] = blink_d;
        dots_d[4] = blink_d;
      end
      MODE_SET_HOURS:   dots_d[5:4] = 2'b11;
      MODE_SET_MINUTES: dots_d[3:2] = 2'b11;
      default:          dots_d = 8'h00;
    endcase
`ifdef HMS_12_HOUR_EN
    dots_d[0] = (hours_d >= 8'h12);
`endif
  end

  // State and output registers; reset overrides every other input.
  always_ff @(posedge clk) begin
    if (rst) begin
      hours_q    <= INIT_HOURS_BCD;
      minutes_q  <= INIT_MINUTES_BCD;
      seconds_q  <= INIT_SECONDS_BCD;
      mode_q     <= MODE_RUN;
      blink_q    <= 1'b0;
      rollover_q <= 1'b0;
      bcd_q      <= {8'h00, hour_display(INIT_HOURS_BCD), INIT_MINUTES_BCD, INIT_SECONDS_BCD};
      dots_q     <= INIT_DOTS;
    end else begin
      hours_q    <= hours_d;
      minutes_q  <= minutes_d;
      seconds_q  <= seconds_d;
      mode_q     <= mode_d;
      blink_q    <= blink_d;
      rollover_q <= rollover_d;
      bcd_q      <= bcd_d;
      dots_q     <= dots_d;
    end
  end

  assign bcd      = bcd_q;
  assign dots     = dots_q;
  assign mode     = mode_q;
  assign rollover = rollover_q;

endmodule

// File: tb/tb_hms_time_counter.sv
// Randomized bench for hms_time_counter: four instances with different INIT values share
// stimulus and are compared every cycle against a seconds-of-day reference model.
module tb_hms_time_counter;

  localparam int NDUT = 4;

`ifdef HMS_12_HOUR_EN
  localparam logic [31:0] EXP_61_TICKS = 32'h0012_0101;
  localparam logic [31:0] EXP_MIDNIGHT = 32'h0012_0000;
  localparam logic [31:0] EXP_SET_DONE = 32'h0011_0000;
`else
  localparam logic [31:0] EXP_61_TICKS = 32'h0000_0101;
  localparam logic [31:0] EXP_MIDNIGHT = 32'h0000_0000;
  localparam logic [31:0] EXP_SET_DONE = 32'h0023_0000;
`endif

  logic clk = 1'b0;
  logic rst, tick, mode_btn, inc_btn, dec_btn;
  logic [31:0] bcd_o  [NDUT];
  logic [7:0]  dots_o [NDUT];
  logic [1:0]  mode_o [NDUT];
  logic        roll_o [NDUT];

  int n_cmp = 0;
  int n_err = 0;

  int ih[NDUT] = '{0, 23, 10, 13};
  int im[NDUT] = '{0, 59, 20, 5};
  int is[NDUT] = '{0, 58, 30, 0};
  int mh[NDUT], mm[NDUT], ms[NDUT], md[NDUT], mb[NDUT], mr[NDUT];

  always #5 clk = ~clk;

  hms_time_counter #(.INIT_HOURS(0), .INIT_MINUTES(0), .INIT_SECONDS(0)) u_dut0 (
    .clk(clk), .rst(rst), .tick(tick), .mode_btn(mode_btn), .inc_btn(inc_btn), .dec_btn(dec_btn),
    .bcd(bcd_o[0]), .dots(dots_o[0]), .mode(mode_o[0]), .rollover(roll_o[0]));
  hms_time_counter #(.INIT_HOURS(23), .INIT_MINUTES(59), .INIT_SECONDS(58)) u_dut1 (
    .clk(clk), .rst(rst), .tick(tick), .mode_btn(mode_btn), .inc_btn(inc_btn), .dec_btn(dec_btn),
    .bcd(bcd_o[1]), .dots(dots_o[1]), .mode(mode_o[1]), .rollover(roll_o[1]));
  hms_time_counter #(.INIT_HOURS(10), .INIT_MINUTES(20), .INIT_SECONDS(30)) u_dut2 (
    .clk(clk), .rst(rst), .tick(tick), .mode_btn(mode_btn), .inc_btn(inc_btn), .dec_btn(dec_btn),
    .bcd(bcd_o[2]), .dots(dots_o[2]), .mode(mode_o[2]), .rollover(roll_o[2]));
  hms_time_counter #(.INIT_HOURS(13), .INIT_MINUTES(5), .INIT_SECONDS(0)) u_dut3 (
    .clk(clk), .rst(rst), .tick(tick), .mode_btn(mode_btn), .inc_btn(inc_btn), .dec_btn(dec_btn),
    .bcd(bcd_o[3]), .dots(dots_o[3]), .mode(mode_o[3]), .rollover(roll_o[3]));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_bcd(input int i);
    int hd;
    hd = mh[i];
`ifdef HMS_12_HOUR_EN
    if (mh[i] == 0) hd = 12;
    else if (mh[i] > 12) hd = mh[i] - 12;
`endif
    return 32'(((hd / 10) << 20) | ((hd % 10) << 16) | ((mm[i] / 10) << 12) |
               ((mm[i] % 10) << 8) | ((ms[i] / 10) << 4) | (ms[i] % 10));
  endfunction

  function automatic logic [31:0] exp_dots(input int i);
    logic [31:0] d;
    d = 32'h0;
    if (md[i] == 0 && mb[i] != 0) d = 32'h14;
    if (md[i] == 1) d = 32'h30;
    if (md[i] == 2) d = 32'h0C;
`ifdef HMS_12_HOUR_EN
    if (mh[i] >= 12) d = d | 32'h01;
`endif
    return d;
  endfunction

  task automatic model_step(input int i, input logic r, input logic t, input logic m,
                            input logic ic, input logic dc);
    int total;
    if (r) begin
      mh[i] = ih[i]; mm[i] = im[i]; ms[i] = is[i];
      md[i] = 0; mb[i] = 0; mr[i] = 0;
    end else begin
      mr[i] = 0;
      case (md[i])
        0: begin
          if (t) begin
            total = mh[i] * 3600 + mm[i] * 60 + ms[i];
            if (total == 86399) mr[i] = 1;
            total = (total + 1) % 86400;
            mh[i] = total / 3600;
            mm[i] = (total / 60) % 60;
            ms[i] = total % 60;
          end
          if (m) begin md[i] = 1; mb[i] = 0; end
          else if (t) mb[i] = 1 - mb[i];
        end
        1: begin
          if (m) begin md[i] = 2; mb[i] = 0; end
          else begin
            if (t) mb[i] = 1 - mb[i];
            if (ic && !dc) mh[i] = (mh[i] + 1) % 24;
            if (dc && !ic) mh[i] = (mh[i] + 23) % 24;
          end
        end
        2: begin
          if (m) begin md[i] = 0; mb[i] = 0; ms[i] = 0; end
          else begin
            if (t) mb[i] = 1 - mb[i];
            if (ic && !dc) mm[i] = (mm[i] + 1) % 60;
            if (dc && !ic) mm[i] = (mm[i] + 59) % 60;
          end
        end
        default: md[i] = 0;
      endcase
    end
  endtask

  task automatic cycle(input logic r, input logic t, input logic m, input logic ic, input logic dc);
    rst = r; tick = t; mode_btn = m; inc_btn = ic; dec_btn = dc;
    @(posedge clk);
    for (int i = 0; i < NDUT; i++) model_step(i, r, t, m, ic, dc);
    @(negedge clk);
    for (int i = 0; i < NDUT; i++) begin
      check_eq($sformatf("d%0d.bcd", i),  bcd_o[i],  exp_bcd(i));
      check_eq($sformatf("d%0d.dots", i), {24'h0, dots_o[i]}, exp_dots(i));
      check_eq($sformatf("d%0d.mode", i), {30'h0, mode_o[i]}, 32'(md[i]));
      check_eq($sformatf("d%0d.roll", i), {31'h0, roll_o[i]}, 32'(mr[i]));
    end
  endtask

  initial begin
    rst = 1'b1; tick = 1'b0; mode_btn = 1'b0; inc_btn = 1'b0; dec_btn = 1'b0;
    for (int i = 0; i < NDUT; i++) model_step(i, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset state, then 61 ticks from 00:00:00.
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("reset_dots0", {24'h0, dots_o[0]}, 32'h0);
    for (int k = 0; k < 61; k++) begin
      cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    check_eq("ticks61_bcd", bcd_o[0], EXP_61_TICKS);

    // Midnight rollover from 23:59:58.
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("midnight_bcd", bcd_o[1], EXP_MIDNIGHT);
    check_eq("midnight_roll", {31'h0, roll_o[1]}, 32'h1);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("midnight_roll_end", {31'h0, roll_o[1]}, 32'h0);

    // Set hours down to 23, minutes up to 00, with ticks in between.
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 11; k++) begin
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    end
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 40; k++) begin
      cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      if (k % 8 == 0) cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    end
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check_eq("set_done_bcd", bcd_o[2], EXP_SET_DONE);
    check_eq("set_done_mode", {30'h0, mode_o[2]}, 32'h0);

    // Simultaneous buttons in SET_MINUTES.
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    check_eq("inc_dec_min", {24'h0, bcd_o[2][15:8]}, 32'h00);
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    check_eq("mode_inc_mode", {30'h0, mode_o[2]}, 32'h0);
    check_eq("mode_inc_min", {24'h0, bcd_o[2][15:8]}, 32'h00);

    // Reset in the middle of an hours edit.
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check_eq("edit_hours", {24'h0, bcd_o[2][23:16]}, 32'h07);
    cycle(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    check_eq("rst_edit_mode", {30'h0, mode_o[2]}, 32'h0);
    check_eq("rst_edit_bcd", bcd_o[2], 32'h0010_2030);
    check_eq("rst_edit_dots", {24'h0, dots_o[2]}, 32'h0);

    // Randomized traffic against the model.
    for (int k = 0; k < 4000; k++) begin
      cycle(($urandom_range(0, 299) == 0) ? 1'b1 : 1'b0,
            ($urandom_range(0, 2) == 0)   ? 1'b1 : 1'b0,
            ($urandom_range(0, 15) == 0)  ? 1'b1 : 1'b0,
            ($urandom_range(0, 4) == 0)   ? 1'b1 : 1'b0,
            ($urandom_range(0, 4) == 0)   ? 1'b1 : 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/hms_time_counter.md
Name: hms_time_counter

Overview:
- Time-of-day counter that drives the BCD input of the 8-digit display multiplexer with HH.MM.SS digits.
- Advances on a one-cycle 1 Hz tick enable.
- Supports user setting of hours and minutes through inc/dec/mode button pulses.
- Holds all time fields as BCD digits internally, so no binary-to-BCD conversion stage is needed.

Parameters:
- INIT_HOURS, 0, hours value (binary, 0-23) loaded on reset
- INIT_MINUTES, 0, minutes value (binary, 0-59) loaded on reset
- INIT_SECONDS, 0, seconds value (binary, 0-59) loaded on reset

Ports:
- clk  input  1  system clock (single clock domain)
- rst  input  1  reset, synchronous, active-high
- tick  input  1  1 Hz enable, one clk cycle wide
- mode_btn  input  1  debounced single-cycle pulse; cycles the set mode
- inc_btn  input  1  debounced single-cycle pulse; increments the selected field
- dec_btn  input  1  debounced single-cycle pulse; decrements the selected field
- bcd  output  32  {8'h00, H1,H0, M1,M0, S1,S0}, one nibble per digit; digit 0 = bcd[3:0]
- dots  output  8  decimal-point enables, bit n = digit n
- mode  output  2  0=RUN, 1=SET_HOURS, 2=SET_MINUTES
- rollover  output  1  one-cycle pulse on the 23:59:59 -> 00:00:00 transition

Behaviour:
- Reset (rst=1 sampled at a clk edge):
  - time loads INIT_* converted to BCD
  - mode=RUN, blink=0, rollover=0
  - bcd[31:24]=0 always
  - Reset has priority over every other input, including mid-edit.
- All state is registered. bcd, dots and mode are driven directly from registers, so they reflect an event one cycle after the input is sampled.
- FSM:
  - RUN -> SET_HOURS on mode_btn
  - SET_HOURS -> SET_MINUTES on mode_btn
  - SET_MINUTES -> RUN on mode_btn; seconds clear to 00 in that same cycle
  - No other transitions.
- RUN, tick=1 (BCD arithmetic, per-digit carry):
  - S0: 9 -> 0 with carry into S1.
  - S1: 5 -> 0 with carry into minutes; minutes roll the same way.
  - Hours: 23 -> 00; otherwise H0 9 -> 0 with carry into H1.
  - rollover=1 for exactly the cycle following the 23:59:59 tick.
- SET_HOURS / SET_MINUTES:
  - tick does not advance time; it only toggles blink.
  - inc_btn: selected field +1, wraps 23->00 (hours) or 59->00 (minutes), with no carry into other fields.
  - dec_btn: selected field -1, wraps 00->23 (hours) or 00->59 (minutes).
  - rollover never asserts.
- In RUN, inc_btn and dec_btn are ignored.
- Simultaneous events:
  - mode_btn with inc/dec in the same cycle: the mode change wins and inc/dec is dropped.
  - inc_btn and dec_btn together: no change.
  - tick with mode_btn in RUN: the tick advance and the mode change both take effect.
- blink:
  - In RUN, blink toggles on every tick.
  - Cleared to 0 on every mode transition.
- dots:
  - RUN: dots[2] = dots[4] = blink (colon-style separators); all other bits 0.
  - SET_HOURS: dots[5:4]=2'b11.
  - SET_MINUTES: dots[3:2]=2'b11.
  - In both set modes all other bits are 0.
- Out-of-range INIT_* values are unsupported. The implementation must flag them with an elaboration-time check.

Optional Feature:
- Macro HMS_12_HOUR_EN.
- Defined:
  - Internal hours stay 0-23; only the bcd hour digits are remapped.
  - Mapping: 0 -> 12, 1-12 unchanged, 13-23 -> 1-11.
  - H1 is shown as 0 when the hour is below 10.
  - dots[0] = PM flag (internal hours >= 12) in all modes.
  - rollover timing is unchanged.
- Undefined: 24-hour output; dots[0] is always 0.

Test Plan:
- Reset with defaults, then 61 ticks -> bcd=32'h0000_0101; rollover never asserts; dots[2] alternates on each tick.
- INIT=23:59:58, then 2 ticks -> bcd=32'h0000_0000 after the second tick; rollover high for exactly one cycle, one cycle after that tick.
- From 10:20:30: mode_btn, dec_btn x11 -> hours=23. Then mode_btn, inc_btn x40 -> minutes=00. Then mode_btn -> bcd=32'h0023_0000, mode=0. Ticks during SET do not change seconds.
- In SET_MINUTES, inc_btn and dec_btn in the same cycle -> no change; mode_btn with inc_btn in the same cycle -> mode=RUN and the minutes value is unchanged.
- rst asserted mid-SET_HOURS with hours edited to 07 -> next cycle mode=0, time=INIT, dots=0.
- HMS_12_HOUR_EN, INIT=00:00:00 -> bcd=32'h0012_0000, dots[0]=0. INIT=13:05:00 -> bcd=32'h0001_0500, dots[0]=1.
